// File: rtl/seq_restoring_div.sv
// seq_restoring_div
//   Sequential unsigned restoring divider. One trial subtraction per clock:
//   the partial remainder is shifted left with the next dividend bit, the
//   divisor is subtracted as a two's-complement add, and the borrow decides
//   both the quotient bit and whether the shifted value is kept (restore).
//
// Parameters
//   WIDTH        operand/result width in bits (2..16)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   busy         high while iterating (WIDTH cycles)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  set with done when the captured divisor was zero
module seq_restoring_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;

    // Trial-subtraction stage
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             carry;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        // Bring the next dividend bit into the partial remainder; the
        // remainder MSB is always zero here because R < D before the shift.
        shifted = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
        trial   = {1'b0, shifted}
                + {1'b0, ~{1'b0, d_reg}}
                + {{(WIDTH+1){1'b0}}, 1'b1};
        carry   = trial[WIDTH+1];
        borrow  = ~carry;
        r_next  = borrow ? shifted : trial[WIDTH:0];
        q_next  = {q_reg[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_reg       <= dividend;
                        d_reg       <= divisor;
                        r_reg       <= '0;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Skip iteration entirely: results are fixed.
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Results come from this final iteration directly.
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[WIDTH-1:0];
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_restoring_div.md
Name: seq_restoring_div

Overview:
Sequential unsigned restoring divider built around the team's two's-complement subtractor stage. It consumes that stage's Difference/Borrow outputs, one trial subtraction per clock. Borrow decides each quotient bit and whether the partial remainder is restored. It sits downstream of the subtractor in the arithmetic-circuits set and is the first multi-cycle, handshaked arithmetic block there.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (valid range 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend, captured on accepted start
divisor  input  WIDTH  unsigned divisor, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  set with done when captured divisor == 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; internal counter and registers=0. Reset mid-RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at edge k, capture dividend into Q register and divisor into D register. Clear the WIDTH+1-bit partial remainder R and set cnt=0.
  - Divisor != 0: go to RUN.
  - Divisor == 0: go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
- RUN, each edge:
  - Form {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Trial-subtract {1'b0, D} as a WIDTH+1-bit two's-complement add; borrow = ~carry.
  - If borrow=0: R=difference, shift 1 into Q LSB.
  - If borrow=1: R keeps the shifted value (restore), shift 0 into Q LSB.
  - Q shifts left by one each iteration. cnt increments.
  - At the edge where cnt reaches WIDTH-1, go to DONE.
- Latency: start accepted at edge k. RUN covers edges k+1..k+WIDTH. done=1 for the cycle following edge k+WIDTH (div-by-zero case: the cycle following edge k). Next edge returns to IDLE and clears done.
- Outputs:
  - quotient, remainder, div_by_zero are registered and update only on entry to DONE.
  - They hold their values until the next DONE entry or reset.
  - div_by_zero clears on the next accepted start.
- busy=1 exactly in RUN (WIDTH cycles). start is ignored in RUN and DONE, and operand inputs may change freely then.
- Earliest new start: in IDLE, one cycle after done. No back-to-back acceptance in the DONE cycle.
- Invariants checked at done (divisor != 0): dividend == quotient*divisor + remainder, and remainder < divisor. No width overflow is possible for unsigned operands.
- Combinational paths: none from inputs to outputs.

Test Plan:
- Reset, then start with dividend=13, divisor=3 (WIDTH=4) -> busy high 4 cycles; done pulses once at 5th cycle after accepting edge; quotient=4, remainder=1, div_by_zero=0.
- Boundary operands: 15/1 -> q=15, r=0; 2/7 -> q=0, r=2; 15/15 -> q=1, r=0; 0/5 -> q=0, r=0. Each has done exactly 1 cycle and busy exactly 4 cycles.
- Divide by zero: 9/0 -> done on cycle after accepting edge, busy never high, quotient=15, remainder=9, div_by_zero=1. Following 6/2 -> q=3, r=0, div_by_zero=0.
- start held high continuously with changing operands during RUN/DONE -> only IDLE-cycle operands used; results match first operands (12/5 -> q=2, r=2); next operation starts from IDLE.
- rst_n pulled low asynchronously at 2nd RUN cycle of 11/3 -> outputs zero immediately, no done. After release, 11/3 -> q=3, r=2.
- Randomized sweep of all 256 operand pairs (WIDTH=4) against reference model -> invariants hold; done count equals accepted start count.
